mul_share_sched: RTL and testbench



---
 rtl/mul_share_sched_pkg.sv | 21 ++
 rtl/mul_pipe_core.sv | 52 +++++
 rtl/mul_share_sched.sv | 130 +++++++++++++
 tb/tb_mul_share_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_sched_pkg.sv
// Shared types and default sizing for the shared-multiplier scheduler.
// The tagged-operation and tagged-result types are sized from these defaults.
package mul_share_sched_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int N_REQ_DEF = 4;
    localparam int DEPTH_DEF = 4;
    localparam int ID_W      = (N_REQ_DEF > 1) ? $clog2(N_REQ_DEF) : 1;

    typedef struct packed {
        logic [ID_W-1:0]      id;
        logic [WIDTH_DEF-1:0] a;
        logic [WIDTH_DEF-1:0] b;
    } op_t;

    typedef struct packed {
        logic [ID_W-1:0]        id;
        logic [2*WIDTH_DEF-1:0] product;
    } res_t;

endpackage

// File: rtl/mul_pipe_core.sv
// Three-stage tagged unsigned multiplier: operand register, two half-width
// partial products, final add. Valid/ID ride alongside; no backpressure.
module mul_pipe_core
    import mul_share_sched_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_vld,
    input  op_t  in_op,
    output logic out_vld,
    output res_t out_res,
    output logic busy
);

    localparam int H  = WIDTH_DEF / 2;
    localparam int PW = 2 * WIDTH_DEF;

    logic            vld_p0, vld_p1, vld_p2;
    op_t             op_p0;
    logic [ID_W-1:0] id_p1, id_p2;
    logic [PW-1:0]   pp_lo_p1, pp_hi_p1, prod_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= in_vld;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        // p0: operands and tag captured
        op_p0    <= in_op;
        // p1: low/high partial products, high one pre-shifted into place
        pp_lo_p1 <= PW'(op_p0.a) * PW'(op_p0.b[H-1:0]);
        pp_hi_p1 <= (PW'(op_p0.a) * PW'(op_p0.b[WIDTH_DEF-1:H])) << H;
        id_p1    <= op_p0.id;
        // p2: exact product
        prod_p2  <= pp_lo_p1 + pp_hi_p1;
        id_p2    <= id_p1;
    end

    assign out_vld         = vld_p2;
    assign out_res.id      = id_p2;
    assign out_res.product = prod_p2;
    assign busy            = vld_p0 | vld_p1 | vld_p2;

endmodule

// File: rtl/mul_share_sched.sv
// Round-robin issue of N_REQ requesters onto one pipelined multiplier, with
// credit flow control guarding an in-order tagged result FIFO.
module mul_share_sched
    import mul_share_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N_REQ = N_REQ_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]     rsp_data,
    output logic                   busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] credits, count;
    logic [ID_W-1:0]  rr_ptr, gnt_id, idx;
    logic [ID_W:0]    sum;
    logic [N_REQ-1:0] grant;
    logic             issue, pop, push, can_issue, core_busy;
    op_t              issue_op;
    res_t             core_res, last_res;
    res_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;
    // A same-cycle pop frees a slot, so it can fund an issue with zero credits.
    assign can_issue = rst_n && ((credits != '0) || pop);

    always_comb begin
        grant    = '0;
        gnt_id   = '0;
        issue    = 1'b0;
        sum      = '0;
        idx      = '0;
        issue_op = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ))
                sum = sum - (ID_W+1)'(N_REQ);
            idx = sum[ID_W-1:0];
            if (can_issue && !issue && req_valid[idx]) begin
                grant[idx] = 1'b1;
                gnt_id     = idx;
                issue      = 1'b1;
            end
        end
        issue_op.id = gnt_id;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                issue_op.a = req_a[k*WIDTH +: WIDTH];
                issue_op.b = req_b[k*WIDTH +: WIDTH];
            end
        end
    end

    assign req_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            credits <= CNT_W'(DEPTH);
        end else begin
            if (issue)
                rr_ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
            case ({issue, pop})
                2'b10:   credits <= credits - CNT_W'(1);
                2'b01:   credits <= credits + CNT_W'(1);
                default: credits <= credits;
            endcase
        end
    end

    mul_pipe_core u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (issue),
        .in_op   (issue_op),
        .out_vld (push),
        .out_res (core_res),
        .busy    (core_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_res <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop) begin
                rd_ptr   <= ptr_inc(rd_ptr);
                last_res <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= core_res;
    end

    assign rsp_id   = rsp_valid ? mem[rd_ptr].id      : last_res.id;
    assign rsp_data = rsp_valid ? mem[rd_ptr].product : last_res.product;
    assign busy     = core_busy || rsp_valid;

endmodule

// File: tb/tb_mul_share_sched.sv
// Scoreboard bench for mul_share_sched: acceptances push hand-computed
// products, a response monitor pops and compares on every transfer.
module tb_mul_share_sched;
    import mul_share_sched_pkg::*;

    localparam int W = 4;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid, rsp_ready;
    logic [ID_W-1:0] rsp_id;
    logic [2*W-1:0] rsp_data;
    logic           busy;

    typedef struct {
        int       id;
        logic [7:0] data;
        int       acc;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       e;
    int         grant_log[$];
    logic [7:0] exp_tab [N];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    bit         chk_lat = 1'b1;

    mul_share_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_q.push_back('{i, exp_tab[i], cyc});
                    grant_log.push_back(i);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rsp: got id %0d data %0h with nothing expected", rsp_id, rsp_data);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_id_data", {22'd0, rsp_id, rsp_data}, {22'd0, ID_W'(e.id), e.data});
                if (chk_lat)
                    chk("rsp_latency", cyc - e.acc, 4);
            end
        end
    end

    task automatic set_op(int i, logic [3:0] a, logic [3:0] b, logic [7:0] p);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        exp_tab[i] = p;
    endtask

    task automatic serve(int cycles);
        logic [N-1:0] g;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            g = req_valid & req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~g;
        end
    endtask

    task automatic wait_idle(string nm);
        int k;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy && sb_q.size() == 0)
                break;
        end
        chk(nm, (k < 60) ? 1 : 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb_q.delete();
        grant_log.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [ID_W-1:0] hid;
        logic [7:0]      hd;
        int              k;
        int              nv;
        int              exp5 [4];
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) exp_tab[i] = '0;
        exp5 = '{3, 0, 1, 2};

        // Test 1: reset state and first grant
        repeat (3) @(posedge clk);
        #1;
        req_valid = '1;
        #1;
        chk("t1_ready_in_reset", req_ready, 0);
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 0);
        chk("t1_rsp_data", rsp_data, 0);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_busy", busy, 0);
        chk("t1_credits", dut.credits, 4);
        @(posedge clk);
        #1;
        set_op(0, 4'h2, 4'h5, 8'h0A);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_first_grant", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle("t1_idle");

        // Test 2: single request, max operands
        set_op(1, 4'hF, 4'hF, 8'hE1);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("t2_grant", req_ready, 4'b0010);
        @(posedge clk);
        #1;
        req_valid = '0;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        chk("t2_rsp_id", rsp_id, 1);
        chk("t2_rsp_data", rsp_data, 8'hE1);
        @(negedge clk);
        chk("t2_busy_after_pop", busy, 0);
        chk("t2_rsp_valid_after_pop", rsp_valid, 0);
        wait_idle("t2_idle");

        // Test 3: all four at once from a fresh pointer
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 4'(i + 1), 4'h3, 8'(3 * (i + 1)));
        req_valid = '1;
        serve(4);
        chk("t3_ngrant", grant_log.size(), 4);
        if (grant_log.size() == 4)
            for (int i = 0; i < 4; i++) chk("t3_grant_order", grant_log[i], i);
        wait_idle("t3_idle");

        // Test 4: requesters 0 and 2 held continuously
        set_op(0, 4'h7, 4'h9, 8'h3F);
        set_op(2, 4'hC, 4'hA, 8'h78);
        grant_log.delete();
        req_valid = 4'b0101;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = '0;
        chk("t4_ngrant", grant_log.size(), 6);
        if (grant_log.size() == 6)
            for (int i = 0; i < 6; i++) chk("t4_grant_alt", grant_log[i], (i % 2) * 2);
        wait_idle("t4_idle");

        // Test 5: backpressure fills credits, then drain
        chk_lat = 1'b0;
        rsp_ready = 1'b0;
        set_op(0, 4'h5, 4'h6, 8'h1E);
        set_op(1, 4'hB, 4'hD, 8'h8F);
        set_op(2, 4'hE, 4'h3, 8'h2A);
        set_op(3, 4'h9, 4'hF, 8'h87);
        grant_log.delete();
        req_valid = '1;
        repeat (6) @(negedge clk);
        hid = rsp_id;
        hd = rsp_data;
        repeat (4) @(negedge clk);
        chk("t5_naccept", grant_log.size(), 4);
        if (grant_log.size() == 4)
            for (int i = 0; i < 4; i++) chk("t5_grant_order", grant_log[i], exp5[i]);
        chk("t5_ready_blocked", req_ready, 0);
        chk("t5_credits", dut.credits, 0);
        chk("t5_head_valid", rsp_valid, 1);
        chk("t5_head_id", rsp_id, 3);
        chk("t5_head_data", rsp_data, 8'h87);
        chk("t5_head_stable", {rsp_id, rsp_data}, {hid, hd});
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t5_grant_on_pop", req_ready, 4'b1000);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle("t5_idle");

        // Test 6: reset with three in flight and one buffered
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (5) @(negedge clk);
        chk("t6_pre_busy", busy, 1);
        chk("t6_pre_rsp_valid", rsp_valid, 1);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_rsp_data", rsp_data, 0);
        chk("t6_rsp_id", rsp_id, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ready_in_reset", req_ready, 0);
        req_valid = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        chk_lat = 1'b1;
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) nv++;
        end
        chk("t6_no_stale_rsp", nv, 0);
        chk("t6_credits", dut.credits, 4);
        @(posedge clk);
        #1;
        set_op(1, 4'h6, 4'h7, 8'h2A);
        req_valid = 4'b0010;
        serve(1);
        wait_idle("t6_idle");

        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
